fetch_queue: RTL and testbench

Decoupling buffer between the instruction ROM/PC loader and the IF_ID register. It captures {pc, inst} pairs produced each fetch cycle and presents them in order to decode with valid/ready handshakes. The ID stage can stall without stalling the PC loader until the queue fills. The hazard detect unit flushes it on branch/jump redirect.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue_mem.sv | 33 +++
 rtl/fetch_queue.sv | 107 ++++++++++
 tb/tb_fetch_queue.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: widths and types shared by the fetch queue and its storage.
//   FQ_DEPTH   - default number of queue entries
//   ROM_ADDR_W - PC / instruction ROM address width (64-word ROM)
//   INST_W     - instruction width
//   INST_NULL  - instruction value the ROM emits when flushed
//   fetch_entry_t - one {pc, inst} fetch record
package fetch_pkg;

    localparam int FQ_DEPTH   = 4;
    localparam int ROM_ADDR_W = 6;
    localparam int INST_W     = 32;

    localparam logic [INST_W-1:0] INST_NULL = 32'h0000_0000;

    typedef struct packed {
        logic [ROM_ADDR_W-1:0] pc;
        logic [INST_W-1:0]     inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: entry storage for the fetch queue.
// DEPTH x WIDTH register array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
// Ports:
//   clk    - system clock, rising edge
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from raddr)
module fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 38
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: decoupling buffer between the PC loader / instruction ROM
// and the IF_ID register. Holds {pc, inst} pairs in order with
// valid/ready handshakes on both sides; flush discards everything.
// Optional build macro FETCH_QUEUE_BYPASS_EN: an empty queue forwards an
// incoming fetch straight to the outputs in the same cycle.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   flush               - redirect from hazard detect, clears the queue
//   in_valid/in_ready   - fetch side handshake
//   in_pc, in_inst      - fetched entry
//   out_valid/out_ready - decode side handshake
//   out_pc, out_inst    - head entry (zero when nothing valid)
//   count               - current occupancy
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH  = FQ_DEPTH,
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = INST_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [ADDR_W-1:0]        in_pc,
    input  logic [DATA_W-1:0]        in_inst,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [DATA_W-1:0]        out_inst,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = ADDR_W + DATA_W;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          we;
    logic [EW-1:0] rdata;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = !full;
    assign count    = wr_ptr - rd_ptr;

    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_inst  = DATA_W'(INST_NULL);
        push      = in_valid && !full;
        pop       = !empty && out_ready;
        if (!empty) begin
            out_valid          = 1'b1;
            {out_pc, out_inst} = rdata;
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        else if (in_valid) begin
            // Forward the incoming fetch; if decode takes it now it never
            // touches storage.
            out_valid = !flush;
            out_pc    = in_pc;
            out_inst  = in_inst;
            if (out_ready) begin
                push = 1'b0;
            end
        end
`endif
    end

    assign we = push && !flush && !rst;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({in_pc, in_inst}),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized checks of fetch_queue against a
// queue-based reference model.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = FQ_DEPTH;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  flush = 1'b0;
    logic                  in_valid = 1'b0;
    logic [ROM_ADDR_W-1:0] in_pc = '0;
    logic [INST_W-1:0]     in_inst = '0;
    logic                  in_ready;
    logic                  out_valid;
    logic [ROM_ADDR_W-1:0] out_pc;
    logic [INST_W-1:0]     out_inst;
    logic                  out_ready = 1'b0;
    logic [$clog2(DEPTH):0] count;

    int total = 0;
    int bad   = 0;

    fetch_entry_t q[$];
    int           cons[$];

    fetch_queue dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic iv,
                         input int pc, input logic [31:0] inst, input logic ordy);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_pc     = ROM_ADDR_W'(pc);
        in_inst   = inst;
        out_ready = ordy;
    endtask

    // Compare every output against the model's view of the current cycle.
    task automatic model_check();
        logic          mv;
        fetch_entry_t  me;
        mv = 1'b0;
        me = '0;
        if (q.size() > 0) begin
            mv = 1'b1;
            me = q[0];
        end else if (BYP && in_valid) begin
            mv      = !flush;
            me.pc   = in_pc;
            me.inst = in_inst;
        end
        check("out_valid", 32'(out_valid), 32'(mv));
        check("out_pc",    32'(out_pc),    32'(me.pc));
        check("out_inst",  out_inst,       me.inst);
        check("in_ready",  32'(in_ready),  32'(q.size() < DEPTH));
        check("count",     32'(count),     32'(q.size()));
    endtask

    // Apply the clock edge to the model using the inputs held this cycle.
    task automatic model_edge();
        int  n;
        bool_t_dummy: begin end
        n = q.size();
        if (rst || flush) begin
            q.delete();
        end else begin
            if (n > 0 && out_ready) begin
                cons.push_back(int'(q[0].pc));
                void'(q.pop_front());
            end
            if (BYP && n == 0 && in_valid && out_ready) begin
                cons.push_back(int'(in_pc));
            end else if (in_valid && n < DEPTH) begin
                q.push_back('{pc: in_pc, inst: in_inst});
            end
        end
    endtask

    task automatic cyc(input logic r, input logic f, input logic iv,
                       input int pc, input logic [31:0] inst, input logic ordy,
                       input bit do_check);
        drive(r, f, iv, pc, inst, ordy);
        @(negedge clk);
        if (do_check) model_check();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_cons(input string tag, input int first, input int num);
        check({tag, "_len"}, 32'(cons.size()), 32'(num));
        for (int i = 0; i < num && i < cons.size(); i++) begin
            check(tag, 32'(cons[i]), 32'(first + i));
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        // reset held two cycles with a fetch presented
        cyc(1'b1, 1'b0, 1'b1, 33, 32'h0000_0033, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 34, 32'h0000_0034, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b1);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_count",     32'(count),     32'd0);
        check("rst_out_inst",  out_inst,       32'd0);
        @(posedge clk);
        model_edge();
        #1;
        cons.delete();

        // fill, overflow attempt, drain
        for (int p = 0; p < 4; p++) cyc(1'b0, 1'b0, 1'b1, p, 32'h13 + p, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 4, 32'h17, 1'b0);
        @(negedge clk);
        check("fill_count",    32'(count),    32'd4);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b1);
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check_cons("fill_order", 0, 4);
        cons.delete();

        // streaming across several wraps
        for (int p = 0; p < 20; p++) begin
            cyc(1'b0, 1'b0, 1'b1, p, 32'h13 + p, 1'b1, 1'b1);
            check("stream_count", 32'(count), BYP ? 32'd0 : 32'd1);
        end
        cyc(1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b1);
        check_cons("stream_order", 0, 20);
        cons.delete();

        // full plus pop: push refused
        for (int p = 0; p < 4; p++) cyc(1'b0, 1'b0, 1'b1, p, 32'h13 + p, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 4, 32'h17, 1'b1, 1'b1);
        check("fullpop_count",    32'(count),    32'd3);
        check("fullpop_in_ready", 32'(in_ready), 32'd1);
        check("fullpop_head",     32'(out_pc),   32'd1);
        check_cons("fullpop_order", 0, 1);
        cyc(1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b1);
        cons.delete();

        // flush with concurrent push and pop
        for (int p = 5; p < 8; p++) cyc(1'b0, 1'b0, 1'b1, p, 32'h13 + p, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 8, 32'h1b, 1'b1, 1'b1);
        check("flush_count",     32'(count),     32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b1);
        check("flush_cons", 32'(cons.size()), 32'd0);

        // bypass / one-cycle latency from empty
        drive(1'b0, 1'b0, 1'b1, 9, 32'h1c, 1'b1);
        @(negedge clk);
        check("byp_out_valid", 32'(out_valid), BYP ? 32'd1 : 32'd0);
        check("byp_out_pc",    32'(out_pc),    BYP ? 32'd9 : 32'd0);
        check("byp_count",     32'(count),     32'd0);
        @(posedge clk);
        model_edge();
        #1;
        drive(1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b1);
        @(negedge clk);
        check("byp_next_valid", 32'(out_valid), BYP ? 32'd0 : 32'd1);
        check("byp_next_pc",    32'(out_pc),    BYP ? 32'd0 : 32'd9);
        @(posedge clk);
        model_edge();
        #1;
        cyc(1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b1);

        // randomized traffic including zero instructions, flush and reset
        for (int i = 0; i < 400; i++) begin
            logic [31:0] inst;
            inst = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
                $urandom_range(0, 3) != 0, int'($urandom_range(0, 63)), inst,
                $urandom_range(0, 2) != 0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
